// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types, default widths and full-subtractor helper
package alu_pkg;

  // Sequencing states for multi-cycle ALU operations
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int SUB_WIDTH = 8;

  // Borrow-out of a 1-bit full subtractor computing a - b - bi
  function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// rtl/full_subtractor_1b.sv - combinational 1-bit full subtractor (a - b - bi)
module full_subtractor_1b
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = fs_borrow(a, b, bi);

endmodule

// File: rtl/subtractor_serial_8b.sv
// rtl/subtractor_serial_8b.sv - bit-serial LSB-first subtractor, optional z/v flags via SUBTRACTOR_SERIAL_FLAGS_EN
module subtractor_serial_8b
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
  ,
  output logic             z,
  output logic             v
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_e       state;
  // a_sh doubles as the difference shift register: each consumed minuend
  // bit frees the MSB slot that receives the next difference bit.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;

  logic             diff_bit;
  logic             brw_next;
  logic [WIDTH-1:0] d_next;

`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor_1b u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (brw),
    .d  (diff_bit),
    .bo (brw_next)
  );

  assign d_next = {diff_bit, a_sh[WIDTH-1:1]};

  // Handshake FSM, serial datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      brw       <= 1'b0;
      cnt       <= '0;
      d         <= '0;
      bo        <= 1'b0;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      z         <= 1'b0;
      v         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            brw      <= bi;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
            // Operand sign bits are shifted away, so keep them for overflow
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end

        SHIFT: begin
          a_sh <= d_next;
          b_sh <= b_sh >> 1;
          brw  <= brw_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            d         <= d_next;
            bo        <= brw_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
            z         <= (d_next == '0);
            v         <= (a_msb != b_msb) && (d_next[WIDTH-1] != a_msb);
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial_8b.sv
// tb/tb_subtractor_serial_8b.sv - scoreboard bench for subtractor_serial_8b, flags checked under SUBTRACTOR_SERIAL_FLAGS_EN
module tb_subtractor_serial_8b;

  parameter int WIDTH = 8;
  localparam logic [WIDTH-1:0] MASK = '1;
  localparam logic [WIDTH-1:0] MSB1 = {1'b1, {(WIDTH-1){1'b0}}};

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
  logic             z;
  logic             v;
`endif

  always #5 clk = ~clk;

  subtractor_serial_8b #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
    ,
    .z         (z),
    .v         (v)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             z;
    logic             v;
    longint           acc;
  } exp_t;

  exp_t   scb[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  bit     rnd_ready   = 1'b0;
  bit     force_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Out-ready driver: either a forced level or random back-pressure
  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Reference model from plain integer arithmetic
  function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                 input logic bbi);
    exp_t   e;
    longint diff, sa, sbv, sdiff, lim;
    diff  = longint'(aa) - longint'(bb) - longint'(bbi);
    e.bo  = (diff < 0);
    e.d   = WIDTH'(diff);
    e.z   = (e.d == '0);
    lim   = longint'(1) << (WIDTH - 1);
    sa    = aa[WIDTH-1] ? longint'(aa) - (lim << 1) : longint'(aa);
    sbv   = bb[WIDTH-1] ? longint'(bb) - (lim << 1) : longint'(bb);
    sdiff = sa - sbv - longint'(bbi);
    e.v   = (sdiff < -lim) || (sdiff > lim - 1);
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head
  bit prev_ov    = 1'b0;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_out_valid", longint'(out_valid), 1);
      if (out_valid) begin
        if (scb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          if (!prev_ov) check("latency", cyc - scb[0].acc, WIDTH);
          check("d", longint'(d), longint'(scb[0].d));
          check("bo", longint'(bo), longint'(scb[0].bo));
          check("in_ready_busy", longint'(in_ready), 0);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
          check("z", longint'(z), longint'(scb[0].z));
          check("v", longint'(v), longint'(scb[0].v));
`endif
          if (out_ready) void'(scb.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_ov    = out_valid;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic bbi);
    exp_t   e;
    bit     ok = 1'b0;
    longint acc = 0;
    a = aa; b = bb; bi = bbi; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1'b1;
        acc = cyc + 1;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      check("issue_timeout", 1, 0);
    end else begin
      e = model(aa, bb, bbi);
      e.acc = acc;
      scb.push_back(e);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (scb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check("drain_timeout", 1, 0);
      scb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_d"}, longint'(d), 0);
    check({tag, "_bo"}, longint'(bo), 0);
`ifdef SUBTRACTOR_SERIAL_FLAGS_EN
    check({tag, "_z"}, longint'(z), 0);
    check({tag, "_v"}, longint'(v), 0);
`endif
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    issue(WIDTH'(5), WIDTH'(3), 1'b0);
    drain();
    issue('0, WIDTH'(1), 1'b0);
    issue(MASK, MASK, 1'b1);
    issue(MSB1, WIDTH'(1), 1'b0);
    issue(WIDTH'(8'h5c), WIDTH'(8'h5c), 1'b0);
    issue('0, MASK, 1'b1);
    drain();

    // Stall in DONE with a competing request that must be ignored
    force_ready = 1'b0;
    issue(WIDTH'(8'h33), WIDTH'(8'h11), 1'b0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("stall_reach_done", longint'(got), 1);
    a = WIDTH'(8'h44); b = WIDTH'(8'h22); bi = 1'b0; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", longint'(in_ready), 1);
    check("release_out_valid", longint'(out_valid), 0);
    check("release_queue_empty", longint'(scb.size()), 0);
    issue(WIDTH'(8'h44), WIDTH'(8'h22), 1'b0);
    drain();

    // Abort mid-SHIFT with reset on the 4th shift edge
    issue(WIDTH'(8'h5a), WIDTH'(8'h3c), 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(scb.pop_back());
    check_idle("abort");
    issue(WIDTH'(8'h10), WIDTH'(8'h10), 1'b0);
    drain();

    // Randomised back-to-back sweep with random back-pressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 1000; n++)
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
